uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_tx_drain.sv | 143 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// ============================================================================
//  Module      : uart_tx_drain
//  Description : Drains bytes from an upstream FIFO and sends each one as an
//                8N1 UART frame, LSB first. Each bit lasts CLKS_PER_BIT clocks.
//                Optional macro UART_TX_PARITY_EN adds a parity bit between
//                the data bits and the stop bit. PARITY_ODD selects even or
//                odd parity.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] fifo_dout,
    output logic       rd_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LATCH  = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;
    logic              parity_bit;
    logic              tx_q;
    logic              rd_en_q;
    logic              tx_next;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign tx      = tx_q;
    assign rd_en   = rd_en_q;

    // State register; reset drops any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; empty only matters in IDLE and on the last STOP cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!empty) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_LATCH;
            ST_LATCH:  next_state = ST_START;
            ST_START:  if (bit_end) next_state = ST_DATA;
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (bit_end) next_state = ST_STOP;
            ST_STOP:   if (bit_end) next_state = empty ? ST_IDLE : ST_FETCH;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Decoded status outputs.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_STOP) && bit_end;
    end

    // Line level for the coming cycle, so tx can be a plain register.
    // A shift happens on the same edge that leaves a data bit, so the next
    // data bit is shreg[1] at that moment.
    always_comb begin
        tx_next = 1'b1;
        case (next_state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = ((state == ST_DATA) && bit_end) ? shreg[1] : shreg[0];
            ST_PARITY: tx_next = parity_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    // Datapath: baud timing, bit index, shift register, line and read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
            rd_en_q    <= 1'b0;
        end else begin
            tx_q    <= tx_next;
            rd_en_q <= (next_state == ST_FETCH);

            if ((state == ST_START) || (state == ST_DATA) ||
                (state == ST_PARITY) || (state == ST_STOP)) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
            end

            if (state == ST_DATA) begin
                if (bit_end) begin
                    bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= 3'd0;
            end

            if (state == ST_LATCH) begin
                shreg      <= fifo_dout;
                parity_bit <= (^fifo_dout) ^ ODD;
            end else if ((state == ST_DATA) && bit_end) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// ============================================================================
//  Module      : tb_uart_tx_drain
//  Description : Self-checking bench for uart_tx_drain (CLKS_PER_BIT = 4).
//                Frame layout follows UART_TX_PARITY_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_drain;

    localparam int CPB  = 4;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CYC = NB * CPB;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par;    // even parity of data, worked out by hand
    } vec_t;

    logic       clk;
    logic       rst;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       rd_en;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:63];
    int         pushed;
    int         popped;
    logic       force_empty;
    int         rd_cnt;
    int         done_cnt;
    int         tests;
    int         fails;

    uart_tx_drain #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .fifo_dout (fifo_dout),
        .rd_en     (rd_en),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: show-ahead-free, data appears the cycle after rd_en.
    assign empty = (pushed == popped) || force_empty;

    initial begin
        popped    = 0;
        fifo_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (rd_en) begin
            fifo_dout <= mem[popped];
            popped    <= popped + 1;
        end
    end

    // Event counters sampled away from the active edge.
    initial begin
        rd_cnt   = 0;
        done_cnt = 0;
    end

    always @(negedge clk) begin
        if (rd_en) rd_cnt   <= rd_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[pushed] = d;
        pushed = pushed + 1;
    endtask

    // Waits (bounded) until the FETCH cycle is visible at a negedge.
    task automatic wait_rd(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rd_seen"}, 64'(rd_en), 64'd1);
    endtask

    // Entered at the FETCH negedge; leaves at the negedge of the last STOP cycle.
    task automatic check_frame(input string nm, input logic [7:0] d, input logic par,
                               input bit raise_empty);
        logic [10:0] fb;
        logic [63:0] exp_tx;
        logic [63:0] act_tx;
        logic [63:0] act_done;
        int          busy_low;
        int          extra_rd;
        exp_tx   = '0;
        act_tx   = '0;
        act_done = '0;
        busy_low = 0;
        extra_rd = 0;
`ifdef UART_TX_PARITY_EN
        fb = {1'b1, par ^ PODD[0], d, 1'b0};
`else
        fb = {1'b0, 1'b1, d, 1'b0};
        if (par) fb[10] = 1'b0;
`endif
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < CPB; j++)
                exp_tx[k*CPB + j] = fb[k];

        chk({nm, "_tx_fetch"}, 64'(tx), 64'd1);
        @(negedge clk);
        chk({nm, "_tx_latch"}, 64'(tx), 64'd1);
        chk({nm, "_rd_latch"}, 64'(rd_en), 64'd0);
        for (int c = 0; c < FRAME_CYC; c++) begin
            @(negedge clk);
            act_tx[c]   = tx;
            act_done[c] = done;
            if (!busy) busy_low++;
            if (rd_en) extra_rd++;
            if (raise_empty && c == 1) force_empty = 1'b1;
        end
        chk({nm, "_tx_frame"}, act_tx, exp_tx);
        chk({nm, "_done"}, act_done, 64'd1 << (FRAME_CYC - 1));
        chk({nm, "_busy_low"}, 64'(busy_low), 64'd0);
        chk({nm, "_extra_rd"}, 64'(extra_rd), 64'd0);
    endtask

    vec_t vecs [5];
    int   rd0;
    int   dn0;
    int   flag_a;
    int   flag_b;
    int   flag_c;

    initial begin
        vecs[0] = '{"a5", 8'hA5, 1'b0};
        vecs[1] = '{"01", 8'h01, 1'b1};
        vecs[2] = '{"80", 8'h80, 1'b1};
        vecs[3] = '{"ff", 8'hFF, 1'b0};
        vecs[4] = '{"3c", 8'h3C, 1'b0};

        tests       = 0;
        fails       = 0;
        pushed      = 0;
        force_empty = 1'b0;
        rst         = 1'b1;

        // Reset state.
        #2;
        chk("rst_tx",   64'(tx),    64'd1);
        chk("rst_rd",   64'(rd_en), 64'd0);
        chk("rst_busy", 64'(busy),  64'd0);
        chk("rst_done", 64'(done),  64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Empty FIFO for 100 cycles: nothing happens.
        flag_a = 0; flag_b = 0; flag_c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_en) flag_a++;
            if (!tx)   flag_b++;
            if (busy)  flag_c++;
        end
        chk("idle_rd",   64'(flag_a), 64'd0);
        chk("idle_tx",   64'(flag_b), 64'd0);
        chk("idle_busy", 64'(flag_c), 64'd0);

        // Single frames from the table.
        for (int v = 0; v < 5; v++) begin
            rd0 = rd_cnt;
            dn0 = done_cnt;
            push(vecs[v].data);
            wait_rd(vecs[v].name);
            check_frame(vecs[v].name, vecs[v].data, vecs[v].par, 1'b0);
            @(negedge clk);
            chk({vecs[v].name, "_idle_after"}, 64'(busy), 64'd0);
            chk({vecs[v].name, "_rd_pulses"}, 64'(rd_cnt - rd0), 64'd1);
            chk({vecs[v].name, "_done_pulses"}, 64'(done_cnt - dn0), 64'd1);
        end

        // Back-to-back bytes: 2-cycle high gap, one read and one done per frame.
        rd0 = rd_cnt;
        dn0 = done_cnt;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        wait_rd("b2b");
        check_frame("b2b_01", 8'h01, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_fetch2", 64'(rd_en), 64'd1);
        check_frame("b2b_80", 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_fetch3", 64'(rd_en), 64'd1);
        check_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_idle", 64'(busy), 64'd0);
        chk("b2b_rd_pulses", 64'(rd_cnt - rd0), 64'd3);
        chk("b2b_done_pulses", 64'(done_cnt - dn0), 64'd3);

        // empty rises during START: frame completes, then IDLE; byte waits.
        push(8'hA5);
        push(8'h01);
        wait_rd("late_empty");
        check_frame("late_empty_a5", 8'hA5, 1'b0, 1'b1);
        @(negedge clk);
        chk("late_empty_idle", 64'(busy), 64'd0);
        chk("late_empty_no_rd", 64'(rd_en), 64'd0);
        force_empty = 1'b0;
        wait_rd("late_empty_resume");
        check_frame("late_empty_01", 8'h01, 1'b1, 1'b0);
        @(negedge clk);

        // Reset during data bit 3 of 0x3C.
        push(8'h3C);
        wait_rd("mid_rst");
        @(negedge clk);                  // LATCH
        repeat (18) @(negedge clk);      // frame cycle 18: data bit 3
        chk("mid_rst_bit3", 64'(tx), 64'd1);
        chk("mid_rst_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx",   64'(tx),    64'd1);
        chk("mid_rst_busy", 64'(busy),  64'd0);
        chk("mid_rst_rd",   64'(rd_en), 64'd0);
        chk("mid_rst_done", 64'(done),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        flag_a = 0; flag_b = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || rd_en) flag_a++;
            if (!tx)           flag_b++;
        end
        chk("post_rst_idle", 64'(flag_a), 64'd0);
        chk("post_rst_tx",   64'(flag_b), 64'd0);

        // Normal operation resumes after reset.
        push(8'hA5);
        wait_rd("post_rst");
        check_frame("post_rst_a5", 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_idle_after", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
